sync_fifo_param: RTL

Parametrised synchronous FIFO: the next generation of the team's 8x8 buffer, with configurable data width and depth, programmable almost-full/almost-empty thresholds, a read-valid strobe, and simultaneous read/write accepted at full. It sits between a producer and a consumer in a single clock domain, using wr_en/rd_en handshakes qualified by the full/empty flags. Optional sticky error flags record overflow and underflow attempts.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_ram.sv | 37 +++
 rtl/sync_fifo_param.sv | 106 ++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helper and default thresholds for sync_fifo_param
package sync_fifo_pkg;

  localparam int DEF_AE_LEVEL  = 2;
  localparam int DEF_AF_MARGIN = 2;

  // Occupancy counter must represent 0..DEPTH inclusive, hence the extra bit.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DEPTH x DATA_W storage, one write port, registered read port
module sync_fifo_ram #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Array is deliberately left out of reset so it can map onto RAM cells.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with threshold flags
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags and err_clr.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter  int AE_LEVEL = DEF_AE_LEVEL,
  localparam int CW       = count_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr,
`endif
  output logic [CW-1:0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rd_valid;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // A write at full is only taken when a read frees the slot in the same cycle.
  assign w_rd_acc = rd_en & ~empty;
  assign w_wr_acc = wr_en & (~full | w_rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (rd_data)
  );

  assign count        = r_count;
  assign rd_valid     = r_rd_valid;
  assign empty        = (r_count == '0);
  assign full         = (r_count == CW'(DEPTH));
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~err_clr) | (wr_en & ~w_wr_acc);
      r_underflow <= (r_underflow & ~err_clr) | (rd_en & empty);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule
